multicycle_controller: RTL and testbench
========================================

Name: multicycle_controller

Overview:
- Main control unit for the multicycle RV32I core (lw, sw, R-type, I-type ALU, beq, jal).
- A Moore FSM sequences the shared ALU through PC increment, branch-target, address and execute phases.
- Generates the ALU control word, immediate select, datapath mux selects and register/memory/PC write enables.
- Sits beside the datapath; consumes the opcode/funct fields from the instruction register and the ALU Zero flag.

Parameters:
(none)

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high; forces FETCH
- op  input  7  instr[6:0]
- funct3  input  3  instr[14:12]
- funct7b5  input  1  instr[30]
- Zero  input  1  ALU result == 0
- ImmSrc  output  2  00 I, 01 S, 10 B, 11 J
- ALUSrcA  output  2  00 PC, 01 OldPC, 10 RD1
- ALUSrcB  output  2  00 RD2, 01 ImmExt, 10 constant 4
- ResultSrc  output  2  00 ALUOut, 01 Data, 10 ALUResult
- AdrSrc  output  1  0 PC, 1 Result
- ALUControl  output  3  000 add, 001 sub, 010 and, 011 or, 101 slt
- IRWrite  output  1  load instruction register
- PCWrite  output  1  load PC
- RegWrite  output  1  register file write
- MemWrite  output  1  data memory write
- Illegal  output  1  unsupported opcode seen in DECODE
- State  output  4  current state code (debug)

Behaviour:
- State codes: FETCH 0, DECODE 1, MEMADR 2, MEMREAD 3, MEMWB 4, MEMWRITE 5, EXECUTER 6, EXECUTEI 7, ALUWB 8, BEQ 9, JAL 10.
- Reset (async, any time, including mid-instruction): state := FETCH immediately. All outputs are a pure function of state, so FETCH outputs are driven while reset is held.
- Transitions:
  - FETCH -> DECODE.
  - DECODE on op:
    - 0000011 or 0100011 -> MEMADR
    - 0110011 -> EXECUTER
    - 0010011 -> EXECUTEI
    - 1100011 -> BEQ
    - 1101111 -> JAL
    - otherwise -> FETCH
  - MEMADR -> MEMREAD if op=0000011, else MEMWRITE.
  - MEMREAD -> MEMWB -> FETCH.
  - MEMWRITE -> FETCH.
  - EXECUTER and EXECUTEI -> ALUWB -> FETCH.
  - BEQ -> FETCH.
  - JAL -> ALUWB.
  - Codes 11-15 -> FETCH; all enables 0 in those codes.
- Per-state outputs (unlisted signals are 0):
  - FETCH: AdrSrc=0, IRWrite=1, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10, PCUpdate=1
  - DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=00
  - MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=00
  - MEMREAD: ResultSrc=00, AdrSrc=1
  - MEMWB: ResultSrc=01, RegWrite=1
  - MEMWRITE: ResultSrc=00, AdrSrc=1, MemWrite=1
  - EXECUTER: ALUSrcA=10, ALUSrcB=00, ALUOp=10
  - EXECUTEI: ALUSrcA=10, ALUSrcB=01, ALUOp=10
  - ALUWB: ResultSrc=00, RegWrite=1
  - BEQ: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, Branch=1
  - JAL: ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCUpdate=1
- PCWrite = PCUpdate | (Branch & Zero). This is the only combinational path from Zero.
- ALUControl from the internal ALUOp:
  - ALUOp=00 -> 000.
  - ALUOp=01 -> 001.
  - ALUOp=10, decoded on funct3:
    - 000: 001 if {op[5],funct7b5}=11, else 000
    - 010: 101
    - 110: 011
    - 111: 010
    - other funct3 values: 000 (never X)
- ImmSrc is decoded from op in every state:
  - 0000011/0010011 -> 00
  - 0100011 -> 01
  - 1100011 -> 10
  - 1101111 -> 11
  - else 00
- Illegal = 1 only in DECODE with an unsupported op (one-cycle pulse). No write enables are asserted for that instruction; the next FETCH proceeds normally.
- Instruction latencies (cycles, FETCH inclusive): lw 5, sw 4, R 4, I 4, beq 3, jal 4.
- Outputs must be glitch-tolerant only at clock edges; no registered outputs beyond state.

Test Plan:
- Reset asserted mid-MEMREAD, asynchronously between edges -> State=0 before the next edge; IRWrite=1, PCWrite=1, MemWrite=0, RegWrite=0.
- lw (op=0000011) -> State 0,1,2,3,4,0. MEMADR: ALUSrcA=10, ALUSrcB=01, ALUControl=000. MEMWB: ResultSrc=01, RegWrite=1. ImmSrc=00.
- R-type sub (op=0110011, funct3=000, funct7b5=1) -> EXECUTER with ALUControl=001, then ALUWB RegWrite=1. I-type addi with funct7b5=1 (op=0010011) -> ALUControl=000.
- beq:
  - Zero=1 -> PCWrite=1 in BEQ, ALUControl=001, ImmSrc=10, 3-cycle instruction.
  - Zero=0 -> PCWrite=0 in BEQ.
- sw then jal:
  - sw: MEMWRITE has MemWrite=1, AdrSrc=1, ImmSrc=01, 4 cycles.
  - jal: JAL has PCWrite=1, ALUSrcA=01, ALUSrcB=10, ImmSrc=11, then ALUWB RegWrite=1.
- op=1111111 -> sequence 0,1,0; Illegal=1 only in DECODE; no RegWrite/MemWrite; funct3=011 with ALUOp=10 yields ALUControl=000.

Source files
------------

// File: rtl/multicycle_controller_if.sv
// Control bundle between the multicycle controller and the RV32I datapath.
// The master modport is the controller side; the slave modport is the datapath side.
interface multicycle_controller_if;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       Zero;
  logic [1:0] ImmSrc;
  logic [1:0] ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] ResultSrc;
  logic       AdrSrc;
  logic [2:0] ALUControl;
  logic       IRWrite;
  logic       PCWrite;
  logic       RegWrite;
  logic       MemWrite;
  logic       Illegal;
  logic [3:0] State;

  modport master (
    input  op, funct3, funct7b5, Zero,
    output ImmSrc, ALUSrcA, ALUSrcB, ResultSrc, AdrSrc, ALUControl,
           IRWrite, PCWrite, RegWrite, MemWrite, Illegal, State
  );

  modport slave (
    output op, funct3, funct7b5, Zero,
    input  ImmSrc, ALUSrcA, ALUSrcB, ResultSrc, AdrSrc, ALUControl,
           IRWrite, PCWrite, RegWrite, MemWrite, Illegal, State
  );
endinterface

// File: rtl/multicycle_controller.sv
// Moore FSM control unit for the multicycle RV32I core (lw, sw, R, I-ALU, beq, jal).
// All outputs are functions of state and instruction fields; Zero only reaches PCWrite.
module multicycle_controller (
  input  logic                           clk,
  input  logic                           reset,
  multicycle_controller_if.master        bus
);

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_ITYPE = 7'b0010011;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECUTER = 4'd6,
    EXECUTEI = 4'd7,
    ALUWB    = 4'd8,
    BEQ      = 4'd9,
    JAL      = 4'd10
  } state_t;

  state_t     state;
  state_t     state_next;
  logic [1:0] alu_op;
  logic [1:0] alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] result_src;
  logic       adr_src;
  logic       ir_write;
  logic       reg_write;
  logic       mem_write;
  logic       pc_update;
  logic       branch;
  logic       illegal;
  logic [2:0] alu_control;
  logic [1:0] imm_src;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= FETCH;
    else       state <= state_next;
  end

  // Unused codes 11-15 fall into the default arm: all enables low, back to FETCH.
  always_comb begin
    state_next = FETCH;
    alu_op     = 2'b00;
    alu_src_a  = 2'b00;
    alu_src_b  = 2'b00;
    result_src = 2'b00;
    adr_src    = 1'b0;
    ir_write   = 1'b0;
    reg_write  = 1'b0;
    mem_write  = 1'b0;
    pc_update  = 1'b0;
    branch     = 1'b0;
    illegal    = 1'b0;
    case (state)
      FETCH: begin
        state_next = DECODE;
        ir_write   = 1'b1;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        pc_update  = 1'b1;
      end
      DECODE: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
        case (bus.op)
          OP_LOAD, OP_STORE: state_next = MEMADR;
          OP_RTYPE:          state_next = EXECUTER;
          OP_ITYPE:          state_next = EXECUTEI;
          OP_BEQ:            state_next = BEQ;
          OP_JAL:            state_next = JAL;
          default:           illegal    = 1'b1;
        endcase
      end
      MEMADR: begin
        state_next = (bus.op == OP_LOAD) ? MEMREAD : MEMWRITE;
        alu_src_a  = 2'b10;
        alu_src_b  = 2'b01;
      end
      MEMREAD: begin
        state_next = MEMWB;
        adr_src    = 1'b1;
      end
      MEMWB: begin
        result_src = 2'b01;
        reg_write  = 1'b1;
      end
      MEMWRITE: begin
        adr_src   = 1'b1;
        mem_write = 1'b1;
      end
      EXECUTER: begin
        state_next = ALUWB;
        alu_src_a  = 2'b10;
        alu_op     = 2'b10;
      end
      EXECUTEI: begin
        state_next = ALUWB;
        alu_src_a  = 2'b10;
        alu_src_b  = 2'b01;
        alu_op     = 2'b10;
      end
      ALUWB: begin
        reg_write = 1'b1;
      end
      BEQ: begin
        alu_src_a = 2'b10;
        alu_op    = 2'b01;
        branch    = 1'b1;
      end
      JAL: begin
        state_next = ALUWB;
        alu_src_a  = 2'b01;
        alu_src_b  = 2'b10;
        pc_update  = 1'b1;
      end
      default: state_next = FETCH;
    endcase
  end

  // Subtract only for R-type (op[5]=1) with funct7b5 set; addi ignores instr[30].
  always_comb begin
    alu_control = 3'b000;
    case (alu_op)
      2'b01: alu_control = 3'b001;
      2'b10: begin
        case (bus.funct3)
          3'b000:  alu_control = ({bus.op[5], bus.funct7b5} == 2'b11) ? 3'b001 : 3'b000;
          3'b010:  alu_control = 3'b101;
          3'b110:  alu_control = 3'b011;
          3'b111:  alu_control = 3'b010;
          default: alu_control = 3'b000;
        endcase
      end
      default: alu_control = 3'b000;
    endcase
  end

  always_comb begin
    imm_src = 2'b00;
    case (bus.op)
      OP_STORE: imm_src = 2'b01;
      OP_BEQ:   imm_src = 2'b10;
      OP_JAL:   imm_src = 2'b11;
      default:  imm_src = 2'b00;
    endcase
  end

  assign bus.ImmSrc     = imm_src;
  assign bus.ALUSrcA    = alu_src_a;
  assign bus.ALUSrcB    = alu_src_b;
  assign bus.ResultSrc  = result_src;
  assign bus.AdrSrc     = adr_src;
  assign bus.ALUControl = alu_control;
  assign bus.IRWrite    = ir_write;
  assign bus.PCWrite    = pc_update | (branch & bus.Zero);
  assign bus.RegWrite   = reg_write;
  assign bus.MemWrite   = mem_write;
  assign bus.Illegal    = illegal;
  assign bus.State      = state;

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: directed instruction walks with literal checks,
// then random instructions compared each cycle against an instruction-level model.
module tb_multicycle_controller;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_ITYPE = 7'b0010011;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;

  typedef struct packed {
    logic [1:0] src_a;
    logic [1:0] src_b;
    logic [1:0] res;
    logic       adr;
    logic       irw;
    logic       regw;
    logic       memw;
  } ctl_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  multicycle_controller_if bus();
  multicycle_controller dut (.clk(clk), .reset(reset), .bus(bus));

  int checks = 0;
  int errors = 0;
  logic [3:0] exp_q[$];

  task automatic chk(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d t=%0t", name, actual, expected, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic bit supported(input logic [6:0] op);
    return op == OP_LOAD || op == OP_STORE || op == OP_RTYPE ||
           op == OP_ITYPE || op == OP_BEQ || op == OP_JAL;
  endfunction

  function automatic ctl_t exp_ctl(input logic [3:0] s);
    ctl_t c;
    c = '0;
    case (s)
      4'd0:  begin c.irw = 1; c.src_b = 2'd2; c.res = 2'd2; end
      4'd1:  begin c.src_a = 2'd1; c.src_b = 2'd1; end
      4'd2:  begin c.src_a = 2'd2; c.src_b = 2'd1; end
      4'd3:  c.adr = 1;
      4'd4:  begin c.res = 2'd1; c.regw = 1; end
      4'd5:  begin c.adr = 1; c.memw = 1; end
      4'd6:  c.src_a = 2'd2;
      4'd7:  begin c.src_a = 2'd2; c.src_b = 2'd1; end
      4'd8:  c.regw = 1;
      4'd9:  c.src_a = 2'd2;
      4'd10: begin c.src_a = 2'd1; c.src_b = 2'd2; end
      default: c = '0;
    endcase
    return c;
  endfunction

  // ALU operation by what the instruction needs in that phase.
  function automatic int exp_alu(input logic [3:0] s, input logic [6:0] op,
                                 input logic [2:0] f3, input logic f7);
    if (s == 4'd9) return 1;
    if (s == 4'd6 || s == 4'd7) begin
      case (f3)
        3'b000:  return (op == OP_RTYPE && f7) ? 1 : 0;
        3'b010:  return 5;
        3'b110:  return 3;
        3'b111:  return 2;
        default: return 0;
      endcase
    end
    return 0;
  endfunction

  function automatic int exp_imm(input logic [6:0] op);
    if (op == OP_STORE) return 1;
    if (op == OP_BEQ)   return 2;
    if (op == OP_JAL)   return 3;
    return 0;
  endfunction

  // Returns instruction latency after queueing its expected state walk.
  function automatic int push_seq(input logic [6:0] op);
    exp_q.push_back(4'd0);
    exp_q.push_back(4'd1);
    case (op)
      OP_LOAD:  begin exp_q.push_back(4'd2); exp_q.push_back(4'd3); exp_q.push_back(4'd4); return 5; end
      OP_STORE: begin exp_q.push_back(4'd2); exp_q.push_back(4'd5); return 4; end
      OP_RTYPE: begin exp_q.push_back(4'd6); exp_q.push_back(4'd8); return 4; end
      OP_ITYPE: begin exp_q.push_back(4'd7); exp_q.push_back(4'd8); return 4; end
      OP_BEQ:   begin exp_q.push_back(4'd9); return 3; end
      OP_JAL:   begin exp_q.push_back(4'd10); exp_q.push_back(4'd8); return 4; end
      default:  return 2;
    endcase
  endfunction

  // ---------------- compare process ----------------
  logic [3:0] cmp_s;
  ctl_t       cmp_c;
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      cmp_s = exp_q.pop_front();
      cmp_c = exp_ctl(cmp_s);
      chk("state",      bus.State,      cmp_s);
      chk("alusrca",    bus.ALUSrcA,    cmp_c.src_a);
      chk("alusrcb",    bus.ALUSrcB,    cmp_c.src_b);
      chk("resultsrc",  bus.ResultSrc,  cmp_c.res);
      chk("adrsrc",     bus.AdrSrc,     cmp_c.adr);
      chk("irwrite",    bus.IRWrite,    cmp_c.irw);
      chk("regwrite",   bus.RegWrite,   cmp_c.regw);
      chk("memwrite",   bus.MemWrite,   cmp_c.memw);
      chk("pcwrite",    bus.PCWrite,
          (cmp_s == 4'd0 || cmp_s == 4'd10 || (cmp_s == 4'd9 && bus.Zero)) ? 1 : 0);
      chk("alucontrol", bus.ALUControl, exp_alu(cmp_s, bus.op, bus.funct3, bus.funct7b5));
      chk("immsrc",     bus.ImmSrc,     exp_imm(bus.op));
      chk("illegal",    bus.Illegal,    (cmp_s == 4'd1 && !supported(bus.op)) ? 1 : 0);
    end
  end

  // ---------------- driver tasks ----------------
  // Called at posedge+1 with the DUT in FETCH; returns latency in cycles.
  task automatic start(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                       output int len);
    bus.op       = op;
    bus.funct3   = f3;
    bus.funct7b5 = f7;
    bus.Zero     = 1'($urandom_range(0, 1));
    len = push_seq(op);
  endtask

  task automatic step(input int z);
    @(posedge clk);
    #1;
    bus.Zero = (z < 0) ? 1'($urandom_range(0, 1)) : 1'(z);
  endtask

  task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input logic f7);
    int len;
    start(op, f3, f7, len);
    repeat (len) step(-1);
  endtask

  logic [6:0] rop;
  int n;
  int pick;

  initial begin
    reset        = 1'b1;
    bus.op       = OP_LOAD;
    bus.funct3   = 3'b000;
    bus.funct7b5 = 1'b0;
    bus.Zero     = 1'b0;
    #3;
    chk("reset_state",   bus.State,    0);
    chk("reset_irwrite", bus.IRWrite,  1);
    chk("reset_pcwrite", bus.PCWrite,  1);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // lw
    start(OP_LOAD, 3'b010, 1'b0, n);
    step(-1); step(-1);
    chk("lw_memadr_state", bus.State,      2);
    chk("lw_memadr_srca",  bus.ALUSrcA,    2);
    chk("lw_memadr_srcb",  bus.ALUSrcB,    1);
    chk("lw_memadr_alu",   bus.ALUControl, 0);
    chk("lw_immsrc",       bus.ImmSrc,     0);
    step(-1); step(-1);
    chk("lw_memwb_state",  bus.State,      4);
    chk("lw_memwb_res",    bus.ResultSrc,  1);
    chk("lw_memwb_regw",   bus.RegWrite,   1);
    step(-1);
    chk("lw_done_state",   bus.State,      0);

    // R-type sub
    start(OP_RTYPE, 3'b000, 1'b1, n);
    step(-1); step(-1);
    chk("sub_alu",         bus.ALUControl, 1);
    step(-1);
    chk("sub_aluwb_regw",  bus.RegWrite,   1);
    step(-1);

    // addi with instr[30]=1 still adds
    start(OP_ITYPE, 3'b000, 1'b1, n);
    step(-1); step(-1);
    chk("addi_alu",        bus.ALUControl, 0);
    step(-1); step(-1);

    // beq taken and not taken
    start(OP_BEQ, 3'b000, 1'b0, n);
    bus.Zero = 1'b1;
    step(1); step(1);
    chk("beq_z1_state",    bus.State,      9);
    chk("beq_z1_pcwrite",  bus.PCWrite,    1);
    chk("beq_alu",         bus.ALUControl, 1);
    chk("beq_immsrc",      bus.ImmSrc,     2);
    step(-1);
    chk("beq_3cycle",      bus.State,      0);
    start(OP_BEQ, 3'b000, 1'b0, n);
    bus.Zero = 1'b0;
    step(0); step(0);
    chk("beq_z0_pcwrite",  bus.PCWrite,    0);
    step(-1);

    // sw
    start(OP_STORE, 3'b010, 1'b0, n);
    step(-1); step(-1); step(-1);
    chk("sw_memwrite",     bus.MemWrite,   1);
    chk("sw_adrsrc",       bus.AdrSrc,     1);
    chk("sw_immsrc",       bus.ImmSrc,     1);
    step(-1);
    chk("sw_4cycle",       bus.State,      0);

    // jal
    start(OP_JAL, 3'b000, 1'b0, n);
    step(-1); step(-1);
    chk("jal_pcwrite",     bus.PCWrite,    1);
    chk("jal_srca",        bus.ALUSrcA,    1);
    chk("jal_srcb",        bus.ALUSrcB,    2);
    chk("jal_immsrc",      bus.ImmSrc,     3);
    step(-1);
    chk("jal_aluwb_regw",  bus.RegWrite,   1);
    step(-1);

    // unsupported opcode
    start(7'b1111111, 3'b011, 1'b0, n);
    step(-1);
    chk("illegal_decode",  bus.Illegal,    1);
    chk("illegal_regw",    bus.RegWrite,   0);
    chk("illegal_memw",    bus.MemWrite,   0);
    step(-1);
    chk("illegal_back",    bus.State,      0);
    chk("illegal_clear",   bus.Illegal,    0);

    // funct3=011 under ALU decode falls back to add
    start(OP_ITYPE, 3'b011, 1'b0, n);
    step(-1); step(-1);
    chk("f3_011_alu",      bus.ALUControl, 0);
    step(-1); step(-1);

    // asynchronous reset mid-MEMREAD
    start(OP_LOAD, 3'b010, 1'b0, n);
    step(-1); step(-1); step(-1);
    chk("memread_state",   bus.State,      3);
    exp_q.delete();
    #2;
    reset = 1'b1;
    #1;
    chk("areset_state",    bus.State,      0);
    chk("areset_irwrite",  bus.IRWrite,    1);
    chk("areset_pcwrite",  bus.PCWrite,    1);
    chk("areset_memwrite", bus.MemWrite,   0);
    chk("areset_regwrite", bus.RegWrite,   0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // random instruction stream
    for (int i = 0; i < 300; i++) begin
      pick = $urandom_range(0, 6);
      case (pick)
        0: rop = OP_LOAD;
        1: rop = OP_STORE;
        2: rop = OP_RTYPE;
        3: rop = OP_ITYPE;
        4: rop = OP_BEQ;
        5: rop = OP_JAL;
        default: rop = 7'($urandom_range(0, 127));
      endcase
      run_instr(rop, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
    end

    chk("queue_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
